// File: rtl/ahb_sram_slave_p_pkg.sv
// Shared AHB-Lite slave definitions: transfer size codes, response codes and
// the data-phase state encoding used by the SRAM slave.
package ahb_sram_slave_p_pkg;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic RESP_OKAY  = 1'b0;
    localparam logic RESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DATA = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } state_e;

    // Widest size code a bus of the given width can carry.
    function automatic logic [2:0] max_size(int data_width);
        return (data_width == 64) ? HSIZE_DWORD : HSIZE_WORD;
    endfunction

endpackage

// File: rtl/ahb_sram_slave_p_lane_mask.sv
// Byte-lane strobe generator: size code plus low address bits give the
// little-endian byte mask and a flag for addresses not aligned to the size.
module ahb_lane_mask #(
    parameter int STRB_W = 4,
    parameter int LSB_W  = 2
) (
    input  logic [2:0]        size_i,
    input  logic [LSB_W-1:0]  addr_lsb_i,
    output logic [STRB_W-1:0] mask_o,
    output logic              misalign_o
);

    int nbytes;

    always_comb begin
        nbytes     = 1 << size_i;
        mask_o     = '0;
        misalign_o = 1'b0;
        for (int k = 0; k < STRB_W; k++) begin
            mask_o[k] = (k >= int'(addr_lsb_i)) && (k < int'(addr_lsb_i) + nbytes);
        end
        for (int k = 0; k < LSB_W; k++) begin
            if (k < int'(size_i) && addr_lsb_i[k]) begin
                misalign_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_sram_slave_p.sv
// Parametrised AHB-Lite SRAM slave with byte-lane writes, programmable wait
// states, two-cycle ERROR response and write-to-read forwarding.
//   state | meaning
//   IDLE  | no data phase in progress, ready high
//   DATA  | OKAY data phase, ready low while wait counter is non-zero
//   ERR1  | first error cycle, ready low, resp ERROR
//   ERR2  | second error cycle, ready high, resp ERROR
module ahb_sram_slave_p
    import ahb_sram_slave_p_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DEPTH       = 8,
    parameter int                    WAIT_STATES = 0,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  sel_i,
    input  logic                  rd_en_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] address_i,
    input  logic [2:0]            size_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  ready_o,
    output logic                  resp_o
);

    localparam int                    STRB_W   = DATA_WIDTH / 8;
    localparam int                    LSB_W    = $clog2(STRB_W);
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(DEPTH * STRB_W);
    localparam logic [2:0]            MAX_SIZE = max_size(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  wr_q, wr_d;
    logic [STRB_W-1:0]     mask_q, mask_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [ADDR_WIDTH-1:0] offset;
    logic [IDX_W-1:0]      acc_idx;
    logic [STRB_W-1:0]     lane_mask;
    logic                  misalign;
    logic                  bad_acc;
    logic                  req;
    logic                  wr_fire;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] fwd_word;

    // Offsets below BASE_ADDR wrap to huge values and fail the range check.
    assign offset  = address_i - BASE_ADDR;
    assign acc_idx = IDX_W'(offset >> LSB_W);
    assign req     = sel_i && (rd_en_i || wr_en_i);
    assign bad_acc = (offset >= SPAN) || (size_i > MAX_SIZE) || misalign;
    assign wr_fire = (state_q == ST_DATA) && (cnt_q == 4'd0) && wr_q;

    ahb_lane_mask #(
        .STRB_W(STRB_W),
        .LSB_W (LSB_W)
    ) u_lane_mask (
        .size_i    (size_i),
        .addr_lsb_i(offset[LSB_W-1:0]),
        .mask_o    (lane_mask),
        .misalign_o(misalign)
    );

    always_comb begin
        wr_word = mem_q[idx_q];
        for (int k = 0; k < STRB_W; k++) begin
            if (mask_q[k]) begin
                wr_word[8*k +: 8] = wr_data_i[8*k +: 8];
            end
        end
    end

    // A read landing on the word being written this edge sees the merged value.
    assign fwd_word = (wr_fire && (idx_q == acc_idx)) ? wr_word : mem_q[acc_idx];

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wr_d      = wr_q;
        mask_d    = mask_q;
        idx_d     = idx_q;
        rd_data_d = rd_data_q;
        ready_o   = 1'b1;
        resp_o    = RESP_OKAY;

        case (state_q)
            ST_IDLE: ;
            ST_DATA: begin
                ready_o = (cnt_q == 4'd0);
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERR1: begin
                ready_o = 1'b0;
                resp_o  = RESP_ERROR;
                state_d = ST_ERR2;
            end
            ST_ERR2: begin
                resp_o  = RESP_ERROR;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (req && ready_o) begin
            if (bad_acc) begin
                state_d = ST_ERR1;
                wr_d    = 1'b0;
            end else begin
                state_d = ST_DATA;
                cnt_d   = 4'(WAIT_STATES);
                wr_d    = wr_en_i;
                mask_d  = lane_mask;
                idx_d   = acc_idx;
                if (!wr_en_i) begin
                    rd_data_d = fwd_word;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            wr_q      <= 1'b0;
            mask_q    <= '0;
            idx_q     <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_q      <= wr_d;
            mask_q    <= mask_d;
            idx_q     <= idx_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Array contents survive reset; only a completing write is suppressed.
    always_ff @(posedge clk_i) begin
        if (!reset_i && wr_fire) begin
            mem_q[idx_q] <= wr_word;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule
